imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time stage directly upstream of the 16-bit MIPS core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, packs bytes into 16-bit instruction words and writes them sequentially into IMEM from address 0.
- Verifies an XOR checksum, then releases the core to run.
- Holds the core in reset until a load completes successfully.

Parameters:
- ADDR_W, 16, width of the IMEM write address; matches PC width.
- DATA_W, 16, instruction word width; fixed at 2 bytes.
- MAX_WORDS, 256, IMEM depth; the largest accepted word count.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Start  in  1  one-cycle pulse that begins a load.
- i_Byte  in  8  stream byte.
- i_Byte_Valid  in  1  i_Byte is valid.
- o_Byte_Ready  out  1  loader can accept a byte.
- o_IM_WE  out  1  IMEM write strobe, one cycle per word.
- o_IM_Addr  out  ADDR_W  IMEM word address.
- o_IM_Data  out  DATA_W  IMEM write data.
- o_CPU_Run  out  1  1 releases the core; 0 holds the core in reset.
- o_Busy  out  1  load in progress.
- o_Done  out  1  last load succeeded.
- o_Err  out  2  0 none, 1 length overflow, 2 checksum mismatch.

Behaviour:
- Reset (i_Rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0; o_IM_Addr=0, o_IM_Data=0.
  - Word counter, length register and checksum cleared.
- Byte transfer: a byte is accepted only on a rising edge where i_Byte_Valid=1 and o_Byte_Ready=1.
  - o_Byte_Ready is registered.
  - o_Byte_Ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
  - No combinational path from i_Byte_Valid to o_Byte_Ready.
- Stream format, MSB first:
  - LEN_HI, LEN_LO: word count N.
  - N pairs of (instr[15:8], instr[7:0]).
  - One checksum byte equal to the XOR of every preceding byte, including the length bytes.
- States and transitions:
  - IDLE: i_Start -> LEN_HI. Clear the counter and checksum; o_Busy=1, o_Done=0, o_Err=0.
  - LEN_HI: accept -> LEN_LO.
  - LEN_LO: accept, then:
    - N > MAX_WORDS -> ERR, o_Err=1, no IMEM writes.
    - N = 0 -> CHK.
    - otherwise -> DATA_HI.
  - DATA_HI: accept -> latch the high byte -> DATA_LO.
  - DATA_LO: accept -> on the same edge register o_IM_WE=1, o_IM_Addr=index, o_IM_Data={hi,byte}.
    - The write is visible one cycle after acceptance; WE is deasserted the following cycle unless another write occurs.
    - index+1; if index+1 = N -> CHK, else -> DATA_HI.
  - CHK: accept, then:
    - byte == running XOR -> RUN: o_Done=1, o_CPU_Run=1, o_Busy=0.
    - otherwise -> ERR: o_Err=2, o_Busy=0.
  - RUN: i_Start -> LEN_HI; o_CPU_Run drops on that same edge.
  - ERR: o_CPU_Run=0. i_Start -> LEN_HI and o_Err clears.
- i_Start while in LEN_HI..CHK is ignored.
- Bytes offered in IDLE/RUN/ERR are not accepted.
- Idle gaps in i_Byte_Valid stall the FSM with no side effects.
- Writes already issued before an error are not undone; the core stays held.
- Index width: clog2(MAX_WORDS)+1 bits, zero-extended onto o_IM_Addr.
- Reset mid-load: immediate abort; o_CPU_Run=0; a partial IMEM image is left as-is.

Decomposition:
- Shared header mips16_loader_defs: state encodings, error codes (ERR_NONE=0, ERR_LEN=1, ERR_CHK=2).
- One sub-module, loader_chksum: 8-bit XOR accumulator with clear and enable inputs.

Test Plan:
- Start; stream 00 02 12 34 AB CD 42 -> writes IM[0]=0x1234, IM[1]=0xABCD; then o_Done=1, o_CPU_Run=1, o_Err=0.
- Same stream with checksum 43 -> both writes occur; o_Err=2, o_CPU_Run=0; i_Start clears o_Err.
- Stream 01 01 (N=257) -> ERR with o_Err=1 after the second byte; no o_IM_WE; o_Byte_Ready=0.
- Stream 00 00 00 -> no writes; RUN with o_Done=1.
- First stream with 0-3 random idle cycles between bytes, plus i_Start pulses mid-load -> identical writes and result.
- Assert i_Rst=0 during DATA_LO of word 1 -> all outputs 0 asynchronously; after release, a fresh full load succeeds.

Source files
------------

// File: rtl/mips16_loader_defs.sv
// Shared definitions for the IMEM boot loader.
// Contents: the loader FSM state encoding, the error codes reported on
// o_Err, and a helper that tells whether a state accepts stream bytes.
package mips16_loader_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHK     = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;

    // True for the states in which the loader consumes stream bytes.
    function automatic logic takes_bytes(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_chksum.sv
// 8-bit XOR accumulator for the boot stream checksum.
// Ports:
//   i_Clk   - clock
//   i_Rst   - asynchronous active-low reset
//   i_Clr   - synchronous clear (wins over i_En)
//   i_En    - fold i_Byte into the running XOR
//   i_Byte  - byte to accumulate
//   o_Sum   - running XOR of all bytes folded in since the last clear
module loader_chksum (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Clr,
    input  logic       i_En,
    input  logic [7:0] i_Byte,
    output logic [7:0] o_Sum
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (i_Clr) begin
            sum_d = 8'h00;
        end else if (i_En) begin
            sum_d = sum_q ^ i_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_Sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader sitting in front of the 16-bit MIPS instruction memory.
// Receives a byte stream (length hi/lo, N instruction byte pairs, XOR
// checksum), writes the packed words into IMEM from address 0 and releases
// the core only after the checksum matches.
// Ports:
//   i_Clk, i_Rst        - clock, asynchronous active-low reset
//   i_Start             - one-cycle pulse starting a load (IDLE/RUN/ERR only)
//   i_Byte, i_Byte_Valid, o_Byte_Ready - byte stream handshake
//   o_IM_WE, o_IM_Addr, o_IM_Data      - IMEM write port (one strobe per word)
//   o_CPU_Run           - 1 releases the core, 0 holds it in reset
//   o_Busy, o_Done      - load in progress / last load succeeded
//   o_Err               - 0 none, 1 length overflow, 2 checksum mismatch
module imem_loader
    import mips16_loader_defs::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 256
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [7:0]        i_Byte,
    input  logic              i_Byte_Valid,
    output logic              o_Byte_Ready,
    output logic              o_IM_WE,
    output logic [ADDR_W-1:0] o_IM_Addr,
    output logic [DATA_W-1:0] o_IM_Data,
    output logic              o_CPU_Run,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [1:0]        o_Err
);

    localparam int          IDX_W = $clog2(MAX_WORDS) + 1;
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_e state_q, state_d;

    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;

    logic              accept;
    logic              start_ok;
    logic [15:0]       len_full;
    logic              len_over;
    logic [IDX_W-1:0]  idx_next;
    logic              last_word;
    logic [7:0]        sum;

    // A byte moves only when the registered ready meets a valid byte.
    assign accept    = i_Byte_Valid && ready_q;
    assign start_ok  = i_Start && ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                                   (state_q == ST_ERR));
    assign len_full  = {len_hi_q, i_Byte};
    assign len_over  = {1'b0, len_full} > MAX_N;
    assign idx_next  = idx_q + 1'b1;
    assign last_word = 32'(idx_next) == 32'(len_q);

    // The checksum byte itself is compared, never folded in.
    loader_chksum u_chksum (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Clr  (start_ok),
        .i_En   (accept && (state_q != ST_CHK)),
        .i_Byte (i_Byte),
        .o_Sum  (sum)
    );

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (i_Start) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (len_over)              state_d = ST_ERR;
                    else if (len_full == 16'd0) state_d = ST_CHK;
                    else                       state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (accept) state_d = last_word ? ST_CHK : ST_DATA_HI;
            end
            ST_CHK: begin
                if (accept) state_d = (i_Byte == sum) ? ST_RUN : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values
    always_comb begin
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        run_d    = run_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        // Ready is registered from the upcoming state, so it never depends
        // combinationally on i_Byte_Valid at the output.
        ready_d  = takes_bytes(state_d);

        if (start_ok) begin
            idx_d  = '0;
            run_d  = 1'b0;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d  = ERR_NONE;
        end

        if (accept) begin
            case (state_q)
                ST_LEN_HI: len_hi_d = i_Byte;
                ST_LEN_LO: begin
                    len_d = len_full;
                    if (len_over) begin
                        err_d  = ERR_LEN;
                        busy_d = 1'b0;
                    end
                end
                ST_DATA_HI: hi_d = i_Byte;
                ST_DATA_LO: begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(idx_q);
                    data_d = DATA_W'({hi_q, i_Byte});
                    idx_d  = idx_next;
                end
                ST_CHK: begin
                    busy_d = 1'b0;
                    if (i_Byte == sum) begin
                        done_d = 1'b1;
                        run_d  = 1'b1;
                    end else begin
                        err_d  = ERR_CHK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            len_hi_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            hi_q     <= '0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_Byte_Ready = ready_q;
    assign o_IM_WE      = we_q;
    assign o_IM_Addr    = addr_q;
    assign o_IM_Data    = data_q;
    assign o_CPU_Run    = run_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: expected IMEM writes go into a queue as the
// stimulus is issued; a monitor pops and compares on every write strobe.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bbyte = 8'h00;
    logic        bvalid = 1'b0;
    logic        ready, we, run, busy, done;
    logic [15:0] addr, data;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(16), .DATA_W(16), .MAX_WORDS(256)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst_n),
        .i_Start      (start),
        .i_Byte       (bbyte),
        .i_Byte_Valid (bvalid),
        .o_Byte_Ready (ready),
        .o_IM_WE      (we),
        .o_IM_Addr    (addr),
        .o_IM_Data    (data),
        .o_CPU_Run    (run),
        .o_Busy       (busy),
        .o_Done       (done),
        .o_Err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (rst_n === 1'b1 && we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", addr, data);
            end else begin
                e = exp_q.pop_front();
                if (addr !== e.a || data !== e.d) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             addr, data, e.a, e.d);
                end
            end
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Called and returns at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk);
        bbyte  = b;
        bvalid = 1'b1;
        start  = with_start;
        for (int c = 0; c < 40; c++) begin
            if (ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        bvalid = 1'b0;
        start  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got ready=0 expected byte %0h accepted", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[], input bit gaps, input bit pokes);
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], gaps ? int'($urandom_range(0, 3)) : 0, pokes && (i == 2 || i == 5));
    endtask

    task automatic wait_not_busy();
        for (int c = 0; c < 20 && busy === 1'b1; c++) @(negedge clk);
    endtask

    logic [7:0] good[]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    logic [7:0] badck[] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    logic [7:0] ovf[]   = '{8'h01, 8'h01};
    logic [7:0] empty[] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] part[]  = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {ready, we, addr, data, run, busy, done, err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", ready, 0);

        // Good load
        pulse_start();
        chk("start_busy", busy, 1);
        chk("start_ready", ready, 1);
        push_wr(16'h0000, 16'h1234);
        push_wr(16'h0001, 16'hABCD);
        send_stream(good, 1'b0, 1'b0);
        wait_not_busy();
        chk("good_done", done, 1);
        chk("good_run", run, 1);
        chk("good_err", err, 0);
        chk("good_ready", ready, 0);

        // Bad checksum, started from RUN
        pulse_start();
        chk("restart_run_drops", run, 0);
        chk("restart_done_clr", done, 0);
        push_wr(16'h0000, 16'h1234);
        push_wr(16'h0001, 16'hABCD);
        send_stream(badck, 1'b0, 1'b0);
        wait_not_busy();
        chk("badck_err", err, 2);
        chk("badck_run", run, 0);
        chk("badck_done", done, 0);
        pulse_start();
        chk("err_cleared", err, 0);
        chk("err_restart_busy", busy, 1);

        // Good load with idle gaps and ignored mid-load start pulses
        push_wr(16'h0000, 16'h1234);
        push_wr(16'h0001, 16'hABCD);
        send_stream(good, 1'b1, 1'b1);
        wait_not_busy();
        chk("gap_done", done, 1);
        chk("gap_run", run, 1);
        chk("gap_err", err, 0);

        // Length overflow (N = 257)
        pulse_start();
        send_stream(ovf, 1'b0, 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_ready", ready, 0);
        chk("ovf_busy", busy, 0);
        chk("ovf_run", run, 0);
        repeat (3) @(negedge clk);
        chk("ovf_err_hold", err, 1);

        // Zero-length image
        pulse_start();
        send_stream(empty, 1'b0, 1'b0);
        wait_not_busy();
        chk("empty_done", done, 1);
        chk("empty_run", run, 1);
        chk("empty_err", err, 0);

        // Reset while waiting for the low byte of word 1
        pulse_start();
        push_wr(16'h0000, 16'h1234);
        send_stream(part, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {ready, we, addr, data, run, busy, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        push_wr(16'h0000, 16'h1234);
        push_wr(16'h0001, 16'hABCD);
        send_stream(good, 1'b0, 1'b0);
        wait_not_busy();
        chk("post_reset_done", done, 1);
        chk("post_reset_run", run, 1);
        chk("post_reset_err", err, 0);

        repeat (2) @(negedge clk);
        chk("writes_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
